// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and baud divider helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Clock cycles per serial bit; truncating division, shared with the receiver.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data_c,
  output logic                           o_full_c,
  output logic                           o_empty_c,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_data_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  assign w_push = i_push && !o_full_c;
  assign w_pop  = i_pop && !o_empty_c;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, FIFO, serialiser on a registered line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [UART_DATA_BITS-1:0]         tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH+1);

  tx_state_e                  r_state;
  tx_state_e                  w_state_nxt;
  logic [BAUD_W-1:0]          r_baud_cnt;
  logic [BAUD_W-1:0]          w_baud_nxt;
  logic [UART_IDX_W-1:0]      r_bit_idx;
  logic [UART_IDX_W-1:0]      w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0]  r_shift;
  logic [UART_DATA_BITS-1:0]  w_shift_nxt;
  logic                       r_tx;
  logic                       w_tx_nxt;

  logic                       w_pop;
  logic [UART_DATA_BITS-1:0]  w_fifo_data;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [CNT_W-1:0]           w_fifo_count;
  logic                       w_bit_end;
  logic                       w_last_bit;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (tx_valid),
    .i_data    (tx_data),
    .i_pop     (w_pop),
    .o_data_c  (w_fifo_data),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign w_bit_end  = (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_idx == UART_IDX_W'(UART_DATA_BITS - 1));

  // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
  assign tx_ready   = !w_fifo_full;
  assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;
  assign tx         = r_tx;
  assign fifo_count = w_fifo_count;

  // Serialiser state, baud counter, shift register and line register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // Next-state decode; the line value for each bit is registered on the edge that starts it.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_data;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = 1'b0;
          w_state_nxt   = ST_START;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          w_tx_nxt      = r_shift[0];
          w_state_nxt   = ST_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (w_last_bit) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + UART_IDX_W'(1);
            w_shift_nxt   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud_cnt + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!w_fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            w_pop         = 1'b1;
            w_shift_nxt   = w_fifo_data;
            w_bit_idx_nxt = '0;
            w_tx_nxt      = 1'b0;
            w_state_nxt   = ST_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + BAUD_W'(1);
        end
      end

      default: begin
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter for the wave generator's serial command link. The design's receiver takes ASCII commands from a host; this block is the return path that carries acknowledgements, status and echo bytes back. Bytes arrive on a valid/ready handshake into a small FIFO and leave as 8N1 frames on a single serial pin, timed against the 25 MHz system clock.

## Interface

- `CLK_HZ`, 25_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `FIFO_DEPTH`, 4: byte FIFO depth; must be a power of two, ≥ 2.
- Derived constant `CLKS_PER_BIT` = `CLK_HZ/BAUD`, integer division; 217 at defaults. Must be ≥ 2.

Ports:

- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte. Defined as `!full`.
- `tx`  out  1  serial line. Idle level is high. Registered.
- `busy`  out  1  high when a frame is in flight or the FIFO is not empty.
- `fifo_count`  out  `$clog2(FIFO_DEPTH+1)`  number of bytes currently queued.

## Operation

- **Accept rule:** a byte is accepted on a rising edge where `tx_valid && tx_ready`.
- **No pass-through when full:** `tx_ready` depends only on the registered count. A pop in the same cycle does not raise `tx_ready` while the FIFO is full.
- **Frame format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START: FIFO non-empty. The byte is popped into the shift register on the same edge.
  - START → DATA: after `CLKS_PER_BIT` cycles.
  - DATA: a 3-bit index counts 0..7. The register shifts once per bit period. DATA → STOP after bit 7's period ends.
  - STOP, on its final cycle: if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1. It clears on every state entry and does not free-run in IDLE.
- **Simultaneous push and pop** on one edge: `fifo_count` is unchanged and both operations take effect.
- **Pointers:** read and write pointers wrap modulo `FIFO_DEPTH`.
- **Reset values:** `tx`=1, `busy`=0, `fifo_count`=0, `tx_ready`=1, state=IDLE, all pointers and counters 0.
- **Reset mid-frame:** the frame is aborted, `tx` returns high on that edge, and the FIFO is flushed. No partial retransmit afterwards.

## Timing

- **Latency:** accept on edge N into an empty FIFO with the FSM in IDLE → pop on edge N+1, with `tx` falling on that same edge.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles. At defaults this is 2170 cycles (86.8 µs).
- **Back-to-back frames:** a stop bit is followed immediately by the next start bit, with zero idle cycles.
- **`busy`:** falls on the edge that ends the last stop bit, provided no new byte was accepted.
- **`tx_ready`:** rises one edge after the pop that makes the FIFO not full.
- **Registered outputs:** `tx` and `fifo_count` are registered. `tx_ready` and `busy` are decoded combinationally from registers only, with no combinational path from inputs.

## Structure

- Shared package `uart_pkg` holds:
  - the tx state enum (IDLE/START/DATA/STOP);
  - `UART_DATA_BITS` = 8;
  - a function computing `CLKS_PER_BIT` from clock and baud, shared with the receiver.
- Sub-module `sync_fifo`: parameterised width and depth, synchronous active-low reset, push/pop/full/empty/count. This block instantiates it with width 8.
- The FSM, baud counter and shift register live in `uart_tx_fifo` itself.

## Test plan

1. **Reset:** hold `rst_n` low for 3 clocks with `tx_valid`=1 and `tx_data`=8'h41 → `tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, and nothing is transmitted after release unless `tx_valid` stays high.
2. **Single byte:** defaults, send 8'h41 → `tx` falls 1 clock after the accept edge. Line sequence is 0 | 1,0,0,0,0,0,1,0 | 1, each level held 217 cycles. `busy` falls after 2170 cycles.
3. **Burst:** `tx_valid` held with bytes 8'h00..8'h04, `FIFO_DEPTH`=4 →
   - 8'h00 is popped immediately;
   - 8'h01..8'h04 fill the FIFO (`fifo_count`=4, `tx_ready`=0);
   - five contiguous frames span exactly 50×217 cycles with no high gap between a stop bit and the following start bit.
4. **Full stall:** with the FIFO full, present 8'hFF →
   - not accepted while `tx_ready`=0;
   - `tx_ready` rises 1 cycle after the pop at the end of the current stop bit;
   - 8'hFF is accepted on the next edge and transmitted in order.
5. **Reset mid-frame:** pull `rst_n` low during data bit 3 of 8'hA5 with 2 bytes queued →
   - `tx`=1 and `fifo_count`=0 on that edge;
   - after release, 8'h55 is sent as a clean frame.
6. **Divider:** `CLK_HZ`=400, `BAUD`=100 (`CLKS_PER_BIT`=4), send 8'hA5 → each bit exactly 4 cycles; frame is 40 cycles; data bits on the line are 1,0,1,0,0,1,0,1.
